fifo_read_ctrl: RTL and testbench

- Read-side drain controller attached to the read port of the team's async FIFO, running in the read clock domain.
- On a start command it pulls exactly `len` words from the FIFO and forwards them on a valid/ready stream.
- It absorbs the FIFO's one-cycle read latency and downstream backpressure in a small internal buffer.
- It reports completion, remaining count and protocol errors (FIFO underflow, missing or unexpected read data).

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_read_ctrl_if.sv | 30 +++
 rtl/fifo_rd_buf.sv | 47 ++++
 rtl/fifo_read_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_read_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BUF_DEPTH_MIN = 2;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Command, FIFO read port and output stream bundle of the drain controller.
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  fifo_empty;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_underflow;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [LEN_WIDTH-1:0]  words_left;

  modport slave (
    input  start, len, fifo_empty, fifo_valid, fifo_rdata, fifo_underflow, m_ready,
    output fifo_rd_en, m_data, m_valid, busy, done, err, words_left
  );

  modport master (
    output start, len, fifo_empty, fifo_valid, fifo_rdata, fifo_underflow, m_ready,
    input  fifo_rd_en, m_data, m_valid, busy, done, err, words_left
  );
endinterface

// File: rtl/fifo_rd_buf.sv
// Small circular output buffer; push and pop may coincide in one cycle.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int OCC_W      = occ_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic [OCC_W-1:0]      occ_o
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]                     occ_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Drains exactly len words from the async FIFO read port onto a valid/ready
// stream, hiding the one-cycle read latency and downstream backpressure.
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int BUF_DEPTH  = 2
) (
  input logic             rd_clk,
  input logic             rst,
  fifo_read_ctrl_if.slave bus
);
  localparam int DEPTH = (BUF_DEPTH < BUF_DEPTH_MIN) ? BUF_DEPTH_MIN : BUF_DEPTH;
  localparam int OCC_W = occ_width(DEPTH);
  localparam int NW    = OCC_W + 1;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
  logic                 inflight_q;
  logic                 err_q, err_d;

  logic [OCC_W-1:0]      occ, occ_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic [NW-1:0]         need;
  logic                  m_valid, push, pop, stray, miss, rd_en;

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (DEPTH),
    .OCC_W      (OCC_W)
  ) u_buf (
    .clk    (rd_clk),
    .rst_n  (rst),
    .push_i (push),
    .din_i  (bus.fifo_rdata),
    .pop_i  (pop),
    .dout_o (head),
    .occ_o  (occ)
  );

  // Space check counts the word in flight and credits a same-cycle pop, so
  // m_ready feeds fifo_rd_en combinationally to sustain one word per cycle.
  always_comb begin
    m_valid = (occ != '0);
    pop     = m_valid && bus.m_ready;
    push    = bus.fifo_valid && inflight_q;
    stray   = bus.fifo_valid && !inflight_q;
    miss    = inflight_q && !bus.fifo_valid;
    need    = NW'(occ) + NW'(inflight_q) - NW'(pop);
    rd_en   = (state_q == ST_READ) && !bus.fifo_empty &&
              (issued_q < len_q) && (need < NW'(DEPTH));
    occ_nxt = occ + OCC_W'(push) - OCC_W'(pop);
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q + LEN_WIDTH'(rd_en) - LEN_WIDTH'(miss);
    words_left_d = (pop && words_left_q != '0) ? words_left_q - 1'b1 : words_left_q;
    err_d        = err_q | stray | miss | (bus.fifo_underflow && state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        len_d        = bus.len;
        issued_d     = '0;
        words_left_d = bus.len;
        err_d        = stray;
        state_d      = (bus.len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: if (issued_q == len_q) state_d = ST_DRAIN;
      // A missed return in DRAIN leaves a word unissued; go back for it.
      ST_DRAIN: begin
        if (issued_q < len_q)                  state_d = ST_READ;
        else if (!inflight_q && occ_nxt == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      words_left_q <= words_left_d;
      inflight_q   <= rd_en;
      err_q        <= err_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_valid ? head : '0;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.words_left = words_left_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a one-cycle-latency FIFO model.
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int LW = 8;

  logic rd_clk = 1'b0;
  logic rst    = 1'b0;

  fifo_read_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_read_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .BUF_DEPTH(2)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] fq[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int cyc = 0, rden_cnt = 0, done_cnt = 0, rd_cnt = 0, miss_idx = 0;
  int first_rd_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, done_cyc = -1;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples outputs at negedge, then plays the FIFO side after the posedge.
  task automatic tick();
    logic rd;
    @(negedge rd_clk);
    cyc++;
    rd = bus.fifo_rd_en;
    if (rd) begin
      rden_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (hold_v) begin
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_data", bus.m_data, hold_d);
    end
    hold_v = bus.m_valid && !bus.m_ready && rst;
    hold_d = bus.m_data;
    if (bus.m_valid && bus.m_ready) begin
      rx.push_back(bus.m_data);
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    @(posedge rd_clk);
    #1;
    bus.fifo_valid = 1'b0;
    if (rd) begin
      rd_cnt++;
      if (rd_cnt != miss_idx && fq.size() > 0) begin
        bus.fifo_valid = 1'b1;
        bus.fifo_rdata = fq.pop_front();
      end
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic clr();
    rx.delete();
    rden_cnt = 0; done_cnt = 0; rd_cnt = 0;
    first_rd_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_xfer(input int n);
    bus.len   = LW'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    chk(tag, done_cnt, 1);
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_n"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      chk($sformatf("%s_%0d", tag, i), rx[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bus.start = 0; bus.len = '0; bus.fifo_empty = 1; bus.fifo_valid = 0;
    bus.fifo_rdata = '0; bus.fifo_underflow = 0; bus.m_ready = 0;
    rst = 0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mdata", bus.m_data, 0);
    chk("rst_wl", bus.words_left, 0);
    chk("rst_rden", bus.fifo_rd_en, 0);
    rst = 1;
    tick();

    // Streaming at full rate.
    clr();
    fq = '{8'hA5, 8'h3C, 8'h10, 8'h11};
    bus.fifo_empty = 0;
    bus.m_ready = 1;
    start_xfer(4);
    chk("t1_rden_first", bus.fifo_rd_en, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_wl_load", bus.words_left, 4);
    run_to_done("t1_done", 30);
    exp_q = '{8'hA5, 8'h3C, 8'h10, 8'h11};
    chk_rx("t1_rx");
    chk("t1_rden_cnt", rden_cnt, 4);
    chk("t1_mv_lat", first_pop_cyc - first_rd_cyc, 2);
    chk("t1_burst", last_pop_cyc - first_pop_cyc, 3);
    chk("t1_done_lat", done_cyc - last_pop_cyc, 1);
    chk("t1_err", bus.err, 0);
    chk("t1_wl_end", bus.words_left, 0);
    chk("t1_done_low", bus.done, 0);
    chk("t1_idle", bus.busy, 0);

    // Backpressure: buffer plus in-flight read fill up, head held.
    clr();
    fq = '{8'hA5, 8'h3C, 8'h10, 8'h11};
    bus.fifo_empty = 0;
    bus.m_ready = 0;
    start_xfer(4);
    for (int i = 0; i < 10 && !bus.m_valid; i++) tick();
    chk("t2_mvalid", bus.m_valid, 1);
    repeat (5) begin
      tick();
      chk("t2_head", bus.m_data, 8'hA5);
    end
    chk("t2_rden_stall", rden_cnt, 2);
    bus.m_ready = 1;
    run_to_done("t2_done", 30);
    chk_rx("t2_rx");
    chk("t2_rden_cnt", rden_cnt, 4);
    chk("t2_err", bus.err, 0);

    // Empty stall, with a start pulse in READ that must be ignored.
    clr();
    fq.delete();
    bus.fifo_empty = 1;
    start_xfer(3);
    repeat (9) tick();
    bus.len = 8'd7;
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("t3_ign_wl", bus.words_left, 3);
    chk("t3_busy", bus.busy, 1);
    repeat (10) tick();
    chk("t3_rden_none", rden_cnt, 0);
    fq = '{8'h01, 8'h02, 8'h03};
    bus.fifo_empty = 0;
    run_to_done("t3_done", 40);
    exp_q = '{8'h01, 8'h02, 8'h03};
    chk_rx("t3_rx");
    repeat (3) tick();
    chk("t3_single_done", done_cnt, 1);
    chk("t3_err", bus.err, 0);

    // Missing return data on the 2nd read: word re-read, err sticky.
    clr();
    miss_idx = 2;
    fq = '{8'h41, 8'h42, 8'h43};
    bus.fifo_empty = 0;
    start_xfer(3);
    run_to_done("t4_done", 40);
    miss_idx = 0;
    exp_q = '{8'h41, 8'h42, 8'h43};
    chk_rx("t4_rx");
    chk("t4_rden_cnt", rden_cnt, 4);
    chk("t4_err", bus.err, 1);
    repeat (3) tick();
    chk("t4_err_sticky", bus.err, 1);

    // len=0 completes immediately and clears err.
    clr();
    bus.len = '0;
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("t5_len0_done", bus.done, 1);
    chk("t5_len0_err_clr", bus.err, 0);
    tick();
    chk("t5_len0_done_low", bus.done, 0);
    chk("t5_len0_rden", rden_cnt, 0);
    chk("t5_len0_done_cnt", done_cnt, 1);

    // Unsolicited read data in IDLE only raises err.
    bus.fifo_valid = 1;
    bus.fifo_rdata = 8'hEE;
    tick();
    chk("t4_stray_err", bus.err, 1);
    chk("t4_stray_mvalid", bus.m_valid, 0);
    chk("t4_stray_busy", bus.busy, 0);

    // Maximum length transfer.
    clr();
    for (int i = 0; i < 255; i++) fq.push_back(8'(i * 7));
    bus.fifo_empty = 0;
    start_xfer(255);
    chk("t5_wl_load", bus.words_left, 255);
    chk("t5_err_clr", bus.err, 0);
    run_to_done("t5_done", 600);
    chk("t5_rx_n", rx.size(), 255);
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 8'(i * 7)) bad++;
    chk("t5_order", bad, 0);
    chk("t5_rden_cnt", rden_cnt, 255);
    repeat (2) tick();
    chk("t5_wl_end", bus.words_left, 0);

    // Reset while the buffer holds two words.
    clr();
    fq = '{8'h61, 8'h62, 8'h63, 8'h64};
    bus.fifo_empty = 0;
    bus.m_ready = 0;
    start_xfer(4);
    repeat (4) tick();
    chk("t6_mvalid", bus.m_valid, 1);
    chk("t6_rden_cnt", rden_cnt, 2);
    rst = 0;
    tick();
    rst = 1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_mvalid0", bus.m_valid, 0);
    chk("t6_mdata0", bus.m_data, 0);
    chk("t6_wl0", bus.words_left, 0);
    chk("t6_rden0", bus.fifo_rd_en, 0);
    chk("t6_err0", bus.err, 0);
    chk("t6_done0", bus.done, 0);
    repeat (3) tick();
    chk("t6_no_done", done_cnt, 0);
    clr();
    bus.m_ready = 1;
    start_xfer(2);
    run_to_done("t6_done", 30);
    exp_q = '{8'h63, 8'h64};
    chk_rx("t6_rx");
    chk("t6_err_end", bus.err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
